// File: rtl/mux8_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_arbiter
//
// Round-robin arbiter for eight requesters sharing one 8:1 datapath mux.
// A winner is picked in IDLE by scanning upward from the requester after the
// last owner, then holds the grant in GRANT until it signals done or drops
// its request. One IDLE cycle always separates consecutive grants.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, an owner is forcibly released after HOLD_MAX cycles in
//   GRANT and timeout pulses for one cycle. When undefined, there is no
//   hold counter and timeout is tied low.
//
// Parameters:
//   HOLD_MAX  maximum cycles one owner may hold the grant (timeout build only)
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset, released synchronously
//   req[7:0]  request per requester, bit i = requester i
//   done      owner finished its transaction; only looked at in GRANT
//   gnt[7:0]  registered one-hot grant, zero when nobody owns the mux
//   state[2:0] registered mux select = index of current or last owner
//   busy      registered, high while in GRANT
//   timeout   registered one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module mux8_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] state,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_owner_q, last_owner_d;
  logic       busy_q, busy_d;

  logic [2:0] winner;
  logic [2:0] scan_idx;
  logic       release_now;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             hold_expired;

  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
  // HOLD_MAX has no effect without the timeout feature.
  if (HOLD_MAX < 1) begin : g_unused_hold_max
  end
`endif

  // Round-robin pick. Offsets are visited from farthest to nearest so the
  // nearest requester after the last owner is written last and wins. Offset
  // 8 wraps to 0, giving the last owner itself the lowest priority.
  always_comb begin
    winner   = last_owner_q;
    scan_idx = last_owner_q;
    for (int i = 8; i >= 1; i--) begin
      scan_idx = last_owner_q + 3'(i);
      if (req[scan_idx]) begin
        winner = scan_idx;
      end
    end
  end

  // A normal release is either an explicit done or the owner withdrawing.
  assign release_now = done | ~req[sel_q];

  // Next-state logic. sel (the mux select) is only rewritten on a new grant,
  // so the mux output stays on the released owner throughout IDLE.
  always_comb begin
    fsm_d        = fsm_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    busy_d       = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    case (fsm_q)
      IDLE: begin
        gnt_d  = 8'h00;
        busy_d = 1'b0;
        if (|req) begin
          fsm_d        = GRANT;
          gnt_d        = 8'h01 << winner;
          sel_d        = winner;
          last_owner_d = winner;
          busy_d       = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          fsm_d  = IDLE;
          gnt_d  = 8'h00;
          busy_d = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // A normal release in the same cycle takes precedence, so the
        // timeout pulse only fires when the owner is still holding on.
        else if (hold_expired) begin
          fsm_d     = IDLE;
          gnt_d     = 8'h00;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        fsm_d  = IDLE;
        gnt_d  = 8'h00;
        busy_d = 1'b0;
      end
    endcase
  end

  // State registers. last_owner resets to 7 so requester 0 is scanned first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= IDLE;
      gnt_q        <= 8'h00;
      sel_q        <= 3'd0;
      last_owner_q <= 3'd7;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign state = sel_q;
  assign busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_arbiter
//
// Directed testbench for mux8_arbiter (HOLD_MAX = 4). Each scenario task
// drives stimulus and compares outputs against hand-computed values. The
// hold-time scenario follows ARB_TIMEOUT_EN so the bench matches whichever
// build it is compiled with.
// ---------------------------------------------------------------------------
module tb_mux8_arbiter;

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] state;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  mux8_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .state   (state),
    .busy    (busy),
    .timeout (timeout)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Never more than one grant bit, checked every cycle away from the edge
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("[TB] FAIL onehot: got gnt=%h, required at most one bit set", gnt);
      end
    end
  end

  // Hard stop in case the run never finishes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; outputs are sampled and inputs driven 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req     = 8'h00;
    done    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 8'h00;
    done    = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt, state, busy, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got gnt=%h state=%0d busy=%b timeout=%b, required 00/0/0/0",
               gnt, state, busy, timeout);
    end
    reset_n = 1'b1;
    done    = 1'b1;
    tick();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL idle_ignores_done: got gnt=%h busy=%b, required 00/0", gnt, busy);
    end
    done = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    req = 8'h01;
    tick();
    checks++;
    if ({gnt, state, busy, timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_grant: got gnt=%h state=%0d busy=%b timeout=%b, required 01/0/1/0",
               gnt, state, busy, timeout);
    end
    done = 1'b1;
    tick();
    checks++;
    if ({gnt, state, busy, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_release: got gnt=%h state=%0d busy=%b timeout=%b, required 00/0/0/0",
               gnt, state, busy, timeout);
    end
    done = 1'b0;
    req  = 8'h00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_gnt [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [2:0] exp_sel [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    apply_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if ({gnt, state, busy} !== {exp_gnt[k], exp_sel[k], 1'b1}) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: got gnt=%h state=%0d busy=%b, required %h/%0d/1",
                 k, gnt, state, busy, exp_gnt[k], exp_sel[k]);
      end
      if (k == 8) break;
      done = 1'b1;
      tick();
      checks++;
      if ({gnt, state, busy} !== {8'h00, exp_sel[k], 1'b0}) begin
        errors++;
        $display("[TB] FAIL rr_idle_%0d: got gnt=%h state=%0d busy=%b, required 00/%0d/0",
                 k, gnt, state, busy, exp_sel[k]);
      end
      done = 1'b0;
      tick();
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    // Last owner is 0 coming in; grant 6 first so the scan starts at 7
    req = 8'h40;
    tick();
    checks++;
    if (gnt !== 8'h40) begin
      errors++;
      $display("[TB] FAIL wrap_setup: got gnt=%h, required 40", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h41;
    tick();
    checks++;
    if ({gnt, state} !== {8'h01, 3'd0}) begin
      errors++;
      $display("[TB] FAIL wrap_first: got gnt=%h state=%0d, required 01/0", gnt, state);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if ({gnt, state} !== {8'h40, 3'd6}) begin
      errors++;
      $display("[TB] FAIL wrap_second: got gnt=%h state=%0d, required 40/6", gnt, state);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
  endtask

  task automatic test_req_drop();
    // Last owner is 6; only requester 3 asks
    req = 8'h08;
    tick();
    checks++;
    if ({gnt, state} !== {8'h08, 3'd3}) begin
      errors++;
      $display("[TB] FAIL drop_grant: got gnt=%h state=%0d, required 08/3", gnt, state);
    end
    // Non-owner request appears while owner holds: must not disturb grant
    req = 8'h09;
    tick();
    checks++;
    if ({gnt, state, busy} !== {8'h08, 3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL drop_hold: got gnt=%h state=%0d busy=%b, required 08/3/1", gnt, state, busy);
    end
    req = 8'h01;
    tick();
    checks++;
    if ({gnt, state, busy, timeout} !== {8'h00, 3'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL drop_release: got gnt=%h state=%0d busy=%b timeout=%b, required 00/3/0/0",
               gnt, state, busy, timeout);
    end
    tick();
    checks++;
    if ({gnt, state} !== {8'h01, 3'd0}) begin
      errors++;
      $display("[TB] FAIL drop_next_owner: got gnt=%h state=%0d, required 01/0", gnt, state);
    end
    // done and request drop together: a single clean release
    done = 1'b1;
    req  = 8'h00;
    tick();
    checks++;
    if ({gnt, busy, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL done_and_drop: got gnt=%h busy=%b timeout=%b, required 00/0/0", gnt, busy, timeout);
    end
    done = 1'b0;
    tick();
    checks++;
    if ({gnt, state, timeout} !== {8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL done_and_drop_idle: got gnt=%h state=%0d timeout=%b, required 00/0/0",
               gnt, state, timeout);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    req = 8'h20;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({gnt, timeout} !== {8'h20, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_cycle_%0d: got gnt=%h timeout=%b, required 20/0", c, gnt, timeout);
      end
      if (c < 4) tick();
    end
    tick();
    checks++;
    if ({gnt, busy, timeout} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL timeout_release: got gnt=%h busy=%b timeout=%b, required 00/0/1", gnt, busy, timeout);
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gnt, timeout} !== {8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL timeout_pulse_width: got gnt=%h timeout=%b, required 00/0", gnt, timeout);
    end
    // done in the last allowed cycle wins over the timeout
    req = 8'h20;
    tick();
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    checks++;
    if ({gnt, timeout} !== {8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL release_beats_timeout: got gnt=%h timeout=%b, required 00/0", gnt, timeout);
    end
    done = 1'b0;
    req  = 8'h00;
    tick();
`else
    for (int c = 1; c <= 120; c++) begin
      checks++;
      if ({gnt, timeout} !== {8'h20, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_cycle_%0d: got gnt=%h timeout=%b, required 20/0", c, gnt, timeout);
      end
      tick();
    end
    done = 1'b1;
    tick();
    checks++;
    if ({gnt, timeout} !== {8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL hold_release: got gnt=%h timeout=%b, required 00/0", gnt, timeout);
    end
    done = 1'b0;
    req  = 8'h00;
    tick();
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 8'h04;
    tick();
    checks++;
    if ({gnt, state} !== {8'h04, 3'd2}) begin
      errors++;
      $display("[TB] FAIL areset_setup: got gnt=%h state=%0d, required 04/2", gnt, state);
    end
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, state, busy, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got gnt=%h state=%0d busy=%b timeout=%b, required 00/0/0/0",
               gnt, state, busy, timeout);
    end
    req = 8'h0C;
    tick();
    checks++;
    if (gnt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL areset_held: got gnt=%h, required 00", gnt);
    end
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if ({gnt, state, busy} !== {8'h04, 3'd2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL areset_rearb: got gnt=%h state=%0d busy=%b, required 04/2/1", gnt, state, busy);
    end
    req = 8'h00;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 8'h00;
    done    = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
